// File: rtl/axis_frame_gen_pkg.sv
// Shared types for the AXI-Stream test-pattern source.
package axis_frame_gen_pkg;

    localparam int FCNT_W = 16;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        LOAD   = 3'd1,
        ACTIVE = 3'd2,
        LGAP   = 3'd3,
        FGAP   = 3'd4
    } state_t;

    typedef enum logic [1:0] {
        MODE_XRAMP = 2'd0,
        MODE_YRAMP = 2'd1,
        MODE_CHECK = 2'd2,
        MODE_FNUM  = 2'd3
    } mode_t;

endpackage

// File: rtl/axis_pattern_pix.sv
// Combinational pixel generator: (x, y, mode, frame number) -> TDATA.
// The checker pattern uses bit 4 of x/y (16-pixel squares), so HWID must be >= 5.
module axis_pattern_pix
    import axis_frame_gen_pkg::*;
#(
    parameter int DWID = 24,
    parameter int HWID = 12
) (
    input  logic [HWID-1:0]   x,
    input  logic [HWID-1:0]   y,
    input  mode_t             mode,
    input  logic [FCNT_W-1:0] fnum,
    output logic [DWID-1:0]   pix
);

    // Select the pattern; sizes are zero-extended or truncated to DWID.
    always_comb begin
        pix = '0;
        case (mode)
            MODE_XRAMP: pix = DWID'(x);
            MODE_YRAMP: pix = DWID'(y);
            MODE_CHECK: pix = {DWID{x[4] ^ y[4]}};
            MODE_FNUM:  pix = DWID'(fnum);
            default:    pix = '0;
        endcase
    end

endmodule

// File: rtl/axis_frame_gen.sv
// AXI-Stream video test-pattern source: whole frames, TUSER = SOF, TLAST = EOL.
// Optional macro AXIS_FRAME_GEN_LINE_GAP_EN inserts LINE_GAP idle cycles after
// every non-final line; without it lines go back-to-back.
module axis_frame_gen
    import axis_frame_gen_pkg::*;
#(
    parameter int DWID      = 24,
    parameter int HWID      = 12,
    parameter int FRAME_GAP = 16,
    parameter int LINE_GAP  = 4
) (
    input  logic              ACLK,
    input  logic              ARESETN,
    input  logic              EN,
    input  logic [1:0]        CFG_MODE,
    input  logic [HWID-1:0]   CFG_HSIZE,
    input  logic [HWID-1:0]   CFG_VSIZE,
    input  logic              AXIS_TREADY,
    output logic [DWID-1:0]   AXIS_TDATA,
    output logic              AXIS_TUSER,
    output logic              AXIS_TLAST,
    output logic              AXIS_TVALID,
    output logic              BUSY,
    output logic [FCNT_W-1:0] FRAME_CNT
);

    // Gap counter is shared by both gap states, sized for the longer one.
    localparam int GMAX = (FRAME_GAP > LINE_GAP) ? FRAME_GAP : LINE_GAP;
    localparam int GW   = (GMAX > 1) ? $clog2(GMAX) : 1;

    state_t            state, nxt;
    mode_t             mode;
    logic [HWID-1:0]   x, y, hsize, vsize;
    logic [FCNT_W-1:0] fcnt;
    logic [GW-1:0]     gcnt;
    logic [DWID-1:0]   pix;
    logic              active, accept, eol, eof;

    assign active = (state == ACTIVE);
    assign accept = active && AXIS_TREADY;
    assign eol    = (x == hsize - HWID'(1));
    assign eof    = eol && (y == vsize - HWID'(1));

    axis_pattern_pix #(.DWID(DWID), .HWID(HWID)) u_pix (
        .x    (x),
        .y    (y),
        .mode (mode),
        .fnum (fcnt),
        .pix  (pix)
    );

    // State register.
    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) state <= IDLE;
        else          state <= nxt;
    end

    // Next-state logic.
    always_comb begin
        nxt = state;
        case (state)
            IDLE:   if (EN) nxt = LOAD;
            LOAD:   nxt = ACTIVE;
            ACTIVE: begin
                if (accept && eol) begin
                    if (eof) begin
                        if (FRAME_GAP == 0) nxt = EN ? LOAD : IDLE;
                        else                nxt = FGAP;
                    end
`ifdef AXIS_FRAME_GEN_LINE_GAP_EN
                    else if (LINE_GAP != 0) begin
                        nxt = LGAP;
                    end
`endif
                end
            end
`ifdef AXIS_FRAME_GEN_LINE_GAP_EN
            LGAP:   if (gcnt == GW'(LINE_GAP - 1)) nxt = ACTIVE;
`endif
            FGAP:   if (gcnt == GW'(FRAME_GAP - 1)) nxt = EN ? LOAD : IDLE;
            default: nxt = IDLE;
        endcase
    end

    // Gap counter restarts on every state change, counts while a gap state holds.
    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN)                                          gcnt <= '0;
        else if ((state == FGAP || state == LGAP) && nxt == state) gcnt <= gcnt + GW'(1);
        else                                                   gcnt <= '0;
    end

    // Config latch in LOAD, pixel position and frame counters on accepted beats.
    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            mode  <= MODE_XRAMP;
            hsize <= '0;
            vsize <= '0;
            x     <= '0;
            y     <= '0;
            fcnt  <= '0;
        end else if (state == LOAD) begin
            mode  <= mode_t'(CFG_MODE);
            hsize <= (CFG_HSIZE == '0) ? HWID'(1) : CFG_HSIZE;
            vsize <= (CFG_VSIZE == '0) ? HWID'(1) : CFG_VSIZE;
            x     <= '0;
            y     <= '0;
        end else if (accept) begin
            if (eol) begin
                x <= '0;
                y <= y + HWID'(1);
                if (eof) fcnt <= fcnt + FCNT_W'(1);
            end else begin
                x <= x + HWID'(1);
            end
        end
    end

    assign AXIS_TVALID = active;
    assign AXIS_TUSER  = active && (x == '0) && (y == '0);
    assign AXIS_TLAST  = active && eol;
    assign AXIS_TDATA  = active ? pix : '0;
    assign BUSY        = (state != IDLE);
    assign FRAME_CNT   = fcnt;

endmodule

// File: tb/tb_axis_frame_gen.sv
// Scoreboard bench for axis_frame_gen: expected beats are queued when a frame
// is started and popped as the DUT delivers accepted beats.
module tb_axis_frame_gen;

    localparam int DWID = 24;
    localparam int HWID = 12;
`ifdef AXIS_FRAME_GEN_LINE_GAP_EN
    localparam int EXP_LG = 4;
`else
    localparam int EXP_LG = 0;
`endif

    typedef struct {
        logic [DWID-1:0] data;
        logic            user;
        logic            last;
        logic            eof;
    } beat_t;

    logic            ACLK = 0, ARESETN = 0, EN = 0, AXIS_TREADY = 0;
    logic [1:0]      CFG_MODE = 0;
    logic [HWID-1:0] CFG_HSIZE = 0, CFG_VSIZE = 0;
    logic [DWID-1:0] AXIS_TDATA;
    logic            AXIS_TUSER, AXIS_TLAST, AXIS_TVALID, BUSY;
    logic [15:0]     FRAME_CNT;

    axis_frame_gen dut (
        .ACLK(ACLK), .ARESETN(ARESETN), .EN(EN), .CFG_MODE(CFG_MODE),
        .CFG_HSIZE(CFG_HSIZE), .CFG_VSIZE(CFG_VSIZE), .AXIS_TREADY(AXIS_TREADY),
        .AXIS_TDATA(AXIS_TDATA), .AXIS_TUSER(AXIS_TUSER), .AXIS_TLAST(AXIS_TLAST),
        .AXIS_TVALID(AXIS_TVALID), .BUSY(BUSY), .FRAME_CNT(FRAME_CNT)
    );

    always #5 ACLK = ~ACLK;

    int    checks = 0, errors = 0;
    int    cyc = 0, last_acc_cyc = 0;
    int    acc_cnt = 0, last_cnt = 0, user_cnt = 0;
    int    fno = 0, lg_run = 0;
    bit    lg_pend = 0, hold_v = 0, rnd = 0;
    beat_t sb[$];
    beat_t hd;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [DWID-1:0] mpix(int x, int y, int m, int f);
        case (m)
            0: return DWID'(x);
            1: return DWID'(y);
            2: return (((x >> 4) ^ (y >> 4)) & 1) ? {DWID{1'b1}} : '0;
            default: return DWID'(f & 16'hFFFF);
        endcase
    endfunction

    task automatic push_frame(input int h, input int v, input int m);
        int hh, vv;
        beat_t e;
        hh = (h == 0) ? 1 : h;
        vv = (v == 0) ? 1 : v;
        for (int yy = 0; yy < vv; yy++)
            for (int xx = 0; xx < hh; xx++) begin
                e.data = mpix(xx, yy, m, fno);
                e.user = (xx == 0 && yy == 0);
                e.last = (xx == hh - 1);
                e.eof  = e.last && (yy == vv - 1);
                sb.push_back(e);
            end
        fno++;
    endtask

    always @(posedge ACLK) cyc++;

    // Random backpressure driver.
    always @(posedge ACLK) begin
        #1;
        if (rnd) AXIS_TREADY = 1'($urandom_range(0, 1));
    end

    // Monitor: hold-stability, scoreboard pop, line-gap measurement.
    always @(negedge ACLK) begin
        beat_t e;
        if (!ARESETN) begin
            hold_v  = 0;
            lg_pend = 0;
            lg_run  = 0;
        end else if (AXIS_TVALID) begin
            if (hold_v) begin
                chk("hold_data", AXIS_TDATA, hd.data);
                chk("hold_user", AXIS_TUSER, hd.user);
                chk("hold_last", AXIS_TLAST, hd.last);
            end
            if (AXIS_TREADY) begin
                if (sb.size() == 0) begin
                    chk("extra_beat", 1, 0);
                end else begin
                    e = sb.pop_front();
                    chk("tdata", AXIS_TDATA, e.data);
                    chk("tuser", AXIS_TUSER, e.user);
                    chk("tlast", AXIS_TLAST, e.last);
                    if (lg_pend) chk("line_gap", lg_run, EXP_LG);
                    lg_pend = e.last && !e.eof;
                end
                acc_cnt++;
                if (AXIS_TLAST) last_cnt++;
                if (AXIS_TUSER) user_cnt++;
                last_acc_cyc = cyc + 1;
                lg_run = 0;
                hold_v = 0;
            end else begin
                hold_v  = 1;
                hd.data = AXIS_TDATA;
                hd.user = AXIS_TUSER;
                hd.last = AXIS_TLAST;
            end
        end else begin
            hold_v = 0;
            lg_run++;
        end
    end

    task automatic wait_beats(input int n);
        int k;
        for (k = 0; k < 20000 && acc_cnt < n; k++) begin
            @(posedge ACLK); #1;
        end
        if (acc_cnt < n) chk("beat_timeout", acc_cnt, n);
    endtask

    task automatic wait_idle(output int gap);
        int k;
        for (k = 0; k < 2000 && BUSY; k++) begin
            @(posedge ACLK); #1;
        end
        if (BUSY) chk("idle_timeout", 1, 0);
        gap = cyc - last_acc_cyc;
    endtask

    task automatic clr_cnt();
        acc_cnt = 0; last_cnt = 0; user_cnt = 0;
    endtask

    // One frame with EN dropped after the first beat; checks counts and idle gap.
    task automatic run_frame(input int h, input int v, input int m, input int nb, input int nl);
        int g;
        CFG_HSIZE = HWID'(h); CFG_VSIZE = HWID'(v); CFG_MODE = 2'(m);
        clr_cnt();
        push_frame(h, v, m);
        EN = 1;
        wait_beats(1);
        EN = 0;
        wait_beats(nb);
        wait_idle(g);
        chk("frm_beats", acc_cnt, nb);
        chk("frm_lasts", last_cnt, nl);
        chk("frm_users", user_cnt, 1);
        chk("frm_sb_empty", sb.size(), 0);
        chk("frm_gap", g, 16);
        chk("frm_fcnt", FRAME_CNT, fno);
    endtask

    initial begin
        int g, t1, t2, t3;
        // Reset state
        #12;
        chk("rst_tvalid", AXIS_TVALID, 0);
        chk("rst_tuser", AXIS_TUSER, 0);
        chk("rst_tlast", AXIS_TLAST, 0);
        chk("rst_tdata", AXIS_TDATA, 0);
        chk("rst_busy", BUSY, 0);
        chk("rst_fcnt", FRAME_CNT, 0);
        @(posedge ACLK); #1; ARESETN = 1;
        @(posedge ACLK); #1;

        // Basic frame 4x3 mode 0 with latency check
        CFG_HSIZE = 4; CFG_VSIZE = 3; CFG_MODE = 0; AXIS_TREADY = 1;
        clr_cnt();
        push_frame(4, 3, 0);
        EN = 1;
        @(posedge ACLK); #1;
        chk("lat_load_tvalid", AXIS_TVALID, 0);
        chk("lat_load_busy", BUSY, 1);
        @(posedge ACLK); #1;
        chk("lat_act_tvalid", AXIS_TVALID, 1);
        chk("lat_act_tuser", AXIS_TUSER, 1);
        EN = 0;
        wait_beats(12);
        @(posedge ACLK); #1;
        chk("f1_fcnt", FRAME_CNT, 1);
        chk("f1_busy_gap", BUSY, 1);
        wait_idle(g);
        chk("f1_gap", g, 16);
        chk("f1_beats", acc_cnt, 12);
        chk("f1_lasts", last_cnt, 3);
        chk("f1_users", user_cnt, 1);

        // Same with random backpressure
        rnd = 1;
        run_frame(4, 3, 0, 12, 3);
        rnd = 0;
        @(posedge ACLK); #1; AXIS_TREADY = 1;

        // Other modes and zero-size handling
        run_frame(3, 4, 1, 12, 4);
        run_frame(34, 18, 2, 612, 18);
        run_frame(0, 2, 0, 2, 2);

        // 1x1 frames back-to-back with EN held, frame-number pattern
        CFG_HSIZE = 1; CFG_VSIZE = 1; CFG_MODE = 3;
        clr_cnt();
        push_frame(1, 1, 3); push_frame(1, 1, 3); push_frame(1, 1, 3);
        EN = 1;
        wait_beats(1); t1 = last_acc_cyc;
        wait_beats(2); t2 = last_acc_cyc;
        wait_beats(3); t3 = last_acc_cyc;
        EN = 0;
        wait_idle(g);
        chk("p11_period_a", t2 - t1, 18);
        chk("p11_period_b", t3 - t2, 18);
        chk("p11_lasts", last_cnt, 3);
        chk("p11_users", user_cnt, 3);
        chk("p11_fcnt", FRAME_CNT, fno);
        chk("p11_sb_empty", sb.size(), 0);

        // Config change mid-frame is ignored; EN drop lets the frame complete
        CFG_HSIZE = 4; CFG_VSIZE = 3; CFG_MODE = 0;
        clr_cnt();
        push_frame(4, 3, 0);
        EN = 1;
        wait_beats(5); CFG_HSIZE = 8;
        wait_beats(6); EN = 0;
        wait_beats(12);
        wait_idle(g);
        repeat (30) @(posedge ACLK); #1;
        chk("cfg_beats", acc_cnt, 12);
        chk("cfg_lasts", last_cnt, 3);
        chk("cfg_idle", BUSY, 0);
        chk("cfg_sb_empty", sb.size(), 0);

        // Reset mid-frame
        CFG_HSIZE = 4; CFG_VSIZE = 3; CFG_MODE = 0;
        clr_cnt();
        push_frame(4, 3, 0);
        EN = 1;
        wait_beats(7);
        #2 ARESETN = 0;
        #1;
        chk("mrst_tvalid", AXIS_TVALID, 0);
        chk("mrst_tlast", AXIS_TLAST, 0);
        chk("mrst_busy", BUSY, 0);
        chk("mrst_fcnt", FRAME_CNT, 0);
        sb.delete();
        fno = 0;
        clr_cnt();
        push_frame(4, 3, 0);
        @(posedge ACLK); #1; ARESETN = 1;
        wait_beats(1);
        chk("mrst_first_user", user_cnt, 1);
        EN = 0;
        wait_beats(12);
        wait_idle(g);
        chk("mrst_beats", acc_cnt, 12);
        chk("mrst_fcnt_after", FRAME_CNT, 1);
        chk("mrst_sb_empty", sb.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
